// File: rtl/perceptron_pkg.sv
// Shared constants for the perceptron compute sequencer:
// operand width, default accumulator width / timeout and FSM state codes.
package perceptron_pkg;

  localparam int DATA_W    = 8;
  localparam int ACC_W_DEF = 24;
  localparam int TIMED_DEF = 50000;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_MAC    = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

endpackage

// File: rtl/perceptron_sequencer_pair_capture.sv
// Per-operand capture: holds the first valid byte seen while enabled.
// Ports: clk, rst, en, valid, data, clear -> hit (flag or capture now), held.
module pair_capture
  import perceptron_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  input  logic              clear,
  output logic              hit,
  output logic [DATA_W-1:0] held
);

  logic flag;

  // hit looks one edge ahead so the FSM can leave WAIT in the capture cycle
  assign hit = flag | (en & valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      flag <= 1'b0;
      held <= '0;
    end else if (clear) begin
      flag <= 1'b0;
    end else if (en && valid && !flag) begin
      flag <= 1'b1;
      held <= data;
    end
  end

endmodule

// File: rtl/perceptron_sequencer.sv
// Perceptron compute controller: pops N input/weight pairs, MACs onto bias.
// Ports: start/n_inputs/bias in, in_/wt_ read/data/valid, busy/done/fire/acc/err.
module perceptron_sequencer
  import perceptron_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int TIMED = TIMED_DEF
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              start,
  input  logic [7:0]        n_inputs,
  input  logic [7:0]        bias,
  output logic              in_read,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              wt_read,
  input  logic [7:0]        wt_data,
  input  logic              wt_valid,
  output logic              busy,
  output logic              done,
  output logic              fire,
  output logic [ACC_W-1:0]  acc,
  output logic              err
);

  localparam int TW = $clog2(TIMED + 1);

  logic [1:0]        state;
  logic [7:0]        cnt;
  logic [TW-1:0]     tcnt;
  logic [ACC_W-1:0]  acc_int;

  logic              wait_en;
  logic              in_hit;
  logic              wt_hit;
  logic              both;
  logic              abort;
  logic              clear;
  logic [DATA_W-1:0] in_byte;
  logic [DATA_W-1:0] wt_byte;
  logic signed [15:0] prod;

  assign wait_en = (state == ST_WAIT);
  assign both    = in_hit & wt_hit;
  assign abort   = wait_en & ~both & (tcnt == TW'(TIMED - 1));
  assign clear   = (state == ST_MAC) | abort;
  assign prod    = $signed(in_byte) * $signed(wt_byte);

  pair_capture u_in_cap (
    .clk   (clk),
    .rst   (nRst),
    .en    (wait_en),
    .valid (in_valid),
    .data  (in_data),
    .clear (clear),
    .hit   (in_hit),
    .held  (in_byte)
  );

  pair_capture u_wt_cap (
    .clk   (clk),
    .rst   (nRst),
    .en    (wait_en),
    .valid (wt_valid),
    .data  (wt_data),
    .clear (clear),
    .hit   (wt_hit),
    .held  (wt_byte)
  );

  always_ff @(posedge clk) begin
    if (nRst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      tcnt    <= '0;
      acc_int <= '0;
      acc     <= '0;
      fire    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      in_read <= 1'b0;
      wt_read <= 1'b0;
    end else begin
      in_read <= 1'b0;
      wt_read <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc_int <= ACC_W'($signed(bias));
            busy    <= 1'b1;
            if (n_inputs != 8'd0) begin
              cnt     <= n_inputs;
              tcnt    <= '0;
              in_read <= 1'b1;
              wt_read <= 1'b1;
              state   <= ST_WAIT;
            end else begin
              state <= ST_FINISH;
            end
          end
        end
        ST_WAIT: begin
          if (both) begin
            state <= ST_MAC;
          end else if (abort) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ST_MAC: begin
          acc_int <= acc_int + ACC_W'(prod);
          cnt     <= cnt - 8'd1;
          if (cnt == 8'd1) begin
            state <= ST_FINISH;
          end else begin
            tcnt    <= '0;
            in_read <= 1'b1;
            wt_read <= 1'b1;
            state   <= ST_WAIT;
          end
        end
        default: begin
          acc   <= acc_int;
          fire  <= ~acc_int[ACC_W-1];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
